uart_tx_arbiter: RTL and testbench
==================================

# uart_tx_arbiter

Round-robin arbiter that shares one `uart_tx` serializer between `N_REQ` byte producers, such as a debug console, status reporter and command echo. It sits directly in front of `uart_tx`:
- It drives `i_data`/`i_dv` from registered outputs.
- It uses `o_busy` as the handshake.
- It gives each requester a one-cycle acknowledge when its byte has been latched.

Back-to-back requests go out with one stop bit between frames.

## Interface
Parameters:
- `N_REQ`, default 4: number of requesters, ≥2.
- `WIDTH`, default 8: data bits per frame. Must match the serializer.
- `TIMEOUT`, default 256: watchdog limit, in clk cycles, for `ISSUE`. Used only with the watchdog compiled in.

Ports:
- `clk` in 1: single clock for the block and the serializer.
- `i_reset` in 1: synchronous, active-high reset.
- `i_req` in N_REQ: per-requester request level.
- `i_data` in N_REQ*WIDTH: requester k's byte at `[k*WIDTH +: WIDTH]`.
- `o_ack` out N_REQ: one-cycle pulse when requester k's byte is accepted or dropped.
- `o_grant` out N_REQ: one-hot current owner; 0 in `IDLE`.
- `o_tx_data` out WIDTH: to serializer `i_data`.
- `o_tx_dv` out 1: to serializer `i_dv`.
- `i_tx_busy` in 1: from serializer `o_busy`.
- `o_busy` out 1: high whenever state ≠ `IDLE`.
- `o_err` out 1: one-cycle pulse on a watchdog abort. Tied 0 when the watchdog is compiled out.

## Operation
States: `IDLE`, `ISSUE`, `SEND`.

Arbitration:
- Search `i_req` starting from pointer `ptr`, wrapping; the first set bit wins.
- On each grant, `ptr` becomes (winner+1) mod N_REQ.

`IDLE`:
- If any `i_req` is set, register `o_grant` = winner and `o_tx_data` = winner's slice, set `o_tx_dv`=1, and go to `ISSUE`.
- Otherwise stay in `IDLE`.

`ISSUE`:
- Hold `o_tx_dv`=1 and `o_tx_data` until `i_tx_busy` is seen high.
- Then, in the next cycle: pulse `o_ack[grant]`, set `o_tx_dv`=0, and go to `SEND`.

`SEND`:
- Wait for `i_tx_busy`=0, which means the serializer is in its stop bit.
- Then arbitrate exactly as in `IDLE`: go to `ISSUE` with a new grant, or to `IDLE` with `o_grant`=0.

Requester rules:
- Hold `i_req[k]` until `o_ack[k]`.
- In the cycle after ack, drop `i_req[k]` or present the next byte.
- Data is captured at grant; later changes to `i_data` do not affect the frame in flight.
- Dropping `i_req` while granted has no effect on the frame in flight.

Boundary conditions:
- Only one requester active: it is re-granted every frame; `ptr` still advances.
- All requests arrive simultaneously: the grant order is ptr, ptr+1, … wrapping.
- `o_tx_dv` is never high in `SEND`, so the serializer never re-latches a byte from its stop bit.
- `i_reset` mid-frame: the next cycle gives state `IDLE` and resets every output. The serializer is reset by the same `i_reset`.

Reset values:
- `o_ack`, `o_grant`, `o_tx_data`, `o_tx_dv`, `o_busy` and `o_err` are all 0.
- `ptr`=0.

## Timing
- Cycle t: request seen in `IDLE`. Cycle t+1: `o_grant` and `o_tx_dv` high.
- `i_tx_busy` rises within one bit period, at the serializer's sample point.
- `o_ack` pulses one cycle after `i_tx_busy` is first seen high, and `o_tx_dv` falls in that same cycle.
- Cycle s: `i_tx_busy` seen low in `SEND`. Cycle s+1: next `o_tx_dv`, if a request is pending. The serializer then goes STOP→START with no idle bit.
- `o_ack` stays high for exactly one cycle; at most one bit of `o_ack` is set at any time.

## Configuration
- With `UART_TX_ARB_WATCHDOG_EN` defined:
  - A cycle counter of width `$clog2(TIMEOUT+1)` runs only in `ISSUE` and clears on entry.
  - If it reaches `TIMEOUT` with `i_tx_busy` still low, the next cycle pulses `o_err` and `o_ack[grant]`, sets `o_tx_dv`=0, and returns to `IDLE`. The byte is dropped and `ptr` has already advanced.
  - If `i_tx_busy` is high in the same cycle the counter reaches `TIMEOUT`, busy wins: the normal ack is given and there is no error.
- Without `UART_TX_ARB_WATCHDOG_EN`: `ISSUE` waits indefinitely and `o_err` is constant 0.

## Test plan
- Single frame:
  - Stimulus: N_REQ=4, DIVISOR=16; `i_req`=0010 with byte 0xA5.
  - Required: grant 0010; one `o_ack[1]`; TX line shows start bit, 1,0,1,0,0,1,0,1, stop bit; `o_busy` returns to 0.
- Round-robin:
  - Stimulus: all four requests held with bytes 0x10, 0x11, 0x12, 0x13.
  - Required: frames sent in order 0x10, 0x11, 0x12, 0x13, 0x10; no idle bits between frames.
- Data capture at grant:
  - Stimulus: change requester 2's `i_data` from 0x3C to 0xFF one cycle after grant.
  - Required: the frame carries 0x3C.
- Reset mid-frame:
  - Stimulus: assert `i_reset` for one cycle during `SEND`.
  - Required: next cycle all outputs are 0 and TX is high; the next request goes to requester 0's search order.
- Watchdog (with macro, TIMEOUT=20):
  - Stimulus: `i_tx_busy` held 0 while `i_req`=0001.
  - Required: `o_err` and `o_ack[0]` pulse together 21 cycles after the grant; `o_tx_dv`=0; state returns to `IDLE`.
- Watchdog tie:
  - Stimulus: `i_tx_busy` rises in the same cycle the counter reaches `TIMEOUT`.
  - Required: normal ack; `o_err` stays 0.

Source files
------------

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: round-robin arbiter sharing one uart_tx serializer
// between N_REQ byte producers. Drives the serializer's i_data/i_dv from
// registered outputs and uses its o_busy as the handshake.
// Optional watchdog on the ISSUE state: define UART_TX_ARB_WATCHDOG_EN.
module uart_tx_arbiter #(
    parameter int N_REQ   = 4,
    parameter int WIDTH   = 8,
    parameter int TIMEOUT = 256
) (
    input  logic                   clk,
    input  logic                   i_reset,
    input  logic [N_REQ-1:0]       i_req,
    input  logic [N_REQ*WIDTH-1:0] i_data,
    output logic [N_REQ-1:0]       o_ack,
    output logic [N_REQ-1:0]       o_grant,
    output logic [WIDTH-1:0]       o_tx_data,
    output logic                   o_tx_dv,
    input  logic                   i_tx_busy,
    output logic                   o_busy,
    output logic                   o_err
);

    localparam int PTR_W = $clog2(N_REQ);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        SEND  = 2'd2
    } state_t;

    if (N_REQ < 2) begin : g_bad_nreq
        $error("uart_tx_arbiter: N_REQ must be at least 2");
    end
    if (TIMEOUT < 1) begin : g_bad_timeout
        $error("uart_tx_arbiter: TIMEOUT must be at least 1");
    end

    state_t               state;
    logic [PTR_W-1:0]     ptr;

    logic [2*N_REQ-1:0]   req_dbl;
    logic [N_REQ-1:0]     req_rot;
    int                   offset;
    int                   win_sum;
    logic                 any_req;
    logic [PTR_W-1:0]     win_idx;
    logic [PTR_W-1:0]     next_ptr;
    logic [N_REQ-1:0]     win_oh;
    logic [WIDTH-1:0]     win_data;
    logic                 arb_en;

`ifdef UART_TX_ARB_WATCHDOG_EN
    localparam int CNT_W = $clog2(TIMEOUT + 1);
    logic [CNT_W-1:0]     wd_cnt;
`endif

    // Rotate the request vector so ptr sits at bit 0, then take the lowest set bit as the winner.
    always_comb begin
        req_dbl  = {i_req, i_req} >> ptr;
        req_rot  = req_dbl[N_REQ-1:0];
        offset   = 0;
        win_sum  = 0;
        any_req  = 1'b0;
        win_idx  = '0;
        next_ptr = '0;
        win_oh   = '0;
        win_data = '0;
        for (int j = N_REQ - 1; j >= 0; j--) begin
            if (req_rot[j]) begin
                any_req = 1'b1;
                offset  = j;
            end
        end
        win_sum = int'(ptr) + offset;
        if (win_sum >= N_REQ) begin
            win_sum = win_sum - N_REQ;
        end
        win_idx  = PTR_W'(win_sum);
        next_ptr = (win_idx == PTR_W'(N_REQ - 1)) ? '0 : win_idx + PTR_W'(1);
        for (int k = 0; k < N_REQ; k++) begin
            if (any_req && (win_idx == PTR_W'(k))) begin
                win_oh[k] = 1'b1;
                win_data  = i_data[k*WIDTH +: WIDTH];
            end
        end
        arb_en = (state == IDLE) || ((state == SEND) && !i_tx_busy);
    end

    // Arbiter FSM: grant and issue a byte, wait for the serializer to take it, then wait for its stop bit.
    always_ff @(posedge clk) begin
        if (i_reset) begin
            state     <= IDLE;
            ptr       <= '0;
            o_ack     <= '0;
            o_grant   <= '0;
            o_tx_data <= '0;
            o_tx_dv   <= 1'b0;
            o_busy    <= 1'b0;
`ifdef UART_TX_ARB_WATCHDOG_EN
            o_err     <= 1'b0;
            wd_cnt    <= '0;
`endif
        end else begin
            o_ack <= '0;
`ifdef UART_TX_ARB_WATCHDOG_EN
            o_err <= 1'b0;
`endif
            if (arb_en) begin
                if (any_req) begin
                    state     <= ISSUE;
                    o_grant   <= win_oh;
                    o_tx_data <= win_data;
                    o_tx_dv   <= 1'b1;
                    o_busy    <= 1'b1;
                    ptr       <= next_ptr;
`ifdef UART_TX_ARB_WATCHDOG_EN
                    wd_cnt    <= '0;
`endif
                end else begin
                    state   <= IDLE;
                    o_grant <= '0;
                    o_tx_dv <= 1'b0;
                    o_busy  <= 1'b0;
                end
            end else if (state == ISSUE) begin
                if (i_tx_busy) begin
                    state   <= SEND;
                    o_ack   <= o_grant;
                    o_tx_dv <= 1'b0;
                end
`ifdef UART_TX_ARB_WATCHDOG_EN
                else if (wd_cnt == CNT_W'(TIMEOUT)) begin
                    state   <= IDLE;
                    o_ack   <= o_grant;
                    o_err   <= 1'b1;
                    o_tx_dv <= 1'b0;
                    o_grant <= '0;
                    o_busy  <= 1'b0;
                end else begin
                    wd_cnt <= wd_cnt + CNT_W'(1);
                end
`endif
            end
        end
    end

`ifndef UART_TX_ARB_WATCHDOG_EN
    assign o_err = 1'b0;
`endif

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb_uart_tx_arbiter: directed bench for uart_tx_arbiter with a behavioural
// 8N1 serializer model (DIVISOR clocks per bit) and a mid-bit line sampler.
// Watchdog scenarios are built only when UART_TX_ARB_WATCHDOG_EN is defined.
module tb_uart_tx_arbiter;

    localparam int N_REQ   = 4;
    localparam int WIDTH   = 8;
    localparam int TIMEOUT = 20;
    localparam int DIVISOR = 16;

    localparam int S_IDLE  = 0;
    localparam int S_START = 1;
    localparam int S_DATA  = 2;
    localparam int S_STOP  = 3;

    logic                   clk;
    logic                   i_reset;
    logic [N_REQ-1:0]       i_req;
    logic [N_REQ*WIDTH-1:0] i_data;
    logic [N_REQ-1:0]       o_ack;
    logic [N_REQ-1:0]       o_grant;
    logic [WIDTH-1:0]       o_tx_data;
    logic                   o_tx_dv;
    logic                   i_tx_busy;
    logic                   o_busy;
    logic                   o_err;

    logic stall      = 1'b0;
    logic force_busy = 1'b0;

    int         ser_state = S_IDLE;
    int         ser_cnt   = 0;
    int         ser_bit   = 0;
    logic [7:0] ser_shift = 8'h00;
    logic       ser_busy  = 1'b0;
    logic       tx        = 1'b1;
    int         cyc       = 0;
    bit         rx_bits[$];
    int         start_cyc[$];
    logic       dv_eff;

    int cmpCount  = 0;
    int failCount = 0;
    int multiAck  = 0;
    int dvWithAck = 0;

    uart_tx_arbiter #(
        .N_REQ  (N_REQ),
        .WIDTH  (WIDTH),
        .TIMEOUT(TIMEOUT)
    ) dut (
        .clk      (clk),
        .i_reset  (i_reset),
        .i_req    (i_req),
        .i_data   (i_data),
        .o_ack    (o_ack),
        .o_grant  (o_grant),
        .o_tx_data(o_tx_data),
        .o_tx_dv  (o_tx_dv),
        .i_tx_busy(i_tx_busy),
        .o_busy   (o_busy),
        .o_err    (o_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign dv_eff    = o_tx_dv && !stall;
    assign i_tx_busy = stall ? force_busy : ser_busy;

    // Serializer model: busy through start and data bits, low in the stop bit, accepts a new byte at stop end.
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (i_reset) begin
            ser_state <= S_IDLE;
            ser_cnt   <= 0;
            ser_busy  <= 1'b0;
            tx        <= 1'b1;
        end else begin
            if (ser_state != S_IDLE && ser_cnt == DIVISOR / 2) rx_bits.push_back(tx);
            case (ser_state)
                S_IDLE: begin
                    if (dv_eff) begin
                        ser_shift <= o_tx_data;
                        ser_state <= S_START;
                        ser_cnt   <= 0;
                        ser_busy  <= 1'b1;
                        tx        <= 1'b0;
                        start_cyc.push_back(cyc);
                    end
                end
                S_START: begin
                    if (ser_cnt == DIVISOR - 1) begin
                        ser_cnt   <= 0;
                        ser_bit   <= 0;
                        tx        <= ser_shift[0];
                        ser_state <= S_DATA;
                    end else ser_cnt <= ser_cnt + 1;
                end
                S_DATA: begin
                    if (ser_cnt == DIVISOR - 1) begin
                        ser_cnt <= 0;
                        if (ser_bit == 7) begin
                            tx        <= 1'b1;
                            ser_busy  <= 1'b0;
                            ser_state <= S_STOP;
                        end else begin
                            ser_bit   <= ser_bit + 1;
                            tx        <= ser_shift[1];
                            ser_shift <= ser_shift >> 1;
                        end
                    end else ser_cnt <= ser_cnt + 1;
                end
                default: begin
                    if (ser_cnt == DIVISOR - 1) begin
                        ser_cnt <= 0;
                        if (dv_eff) begin
                            ser_shift <= o_tx_data;
                            ser_state <= S_START;
                            ser_busy  <= 1'b1;
                            tx        <= 1'b0;
                            start_cyc.push_back(cyc);
                        end else ser_state <= S_IDLE;
                    end else ser_cnt <= ser_cnt + 1;
                end
            endcase
        end
    end

    // Protocol monitor: ack must be one-hot-or-zero and never coincide with a live data-valid.
    always @(posedge clk) begin
        if (!i_reset) begin
            if ((o_ack & (o_ack - 4'd1)) != 4'd0) multiAck <= multiAck + 1;
            if (o_tx_dv && (o_ack != 4'd0)) dvWithAck <= dvWithAck + 1;
        end
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        cmpCount++;
        if (observed !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic [N_REQ-1:0] req, input logic [N_REQ*WIDTH-1:0] data);
        i_req  = req;
        i_data = data;
    endtask

    task automatic applyReset(input string tag);
        i_reset = 1'b1;
        @(negedge clk);
        checkOutput({tag, "_ack"},   32'(o_ack), 32'h0);
        checkOutput({tag, "_grant"}, 32'(o_grant), 32'h0);
        checkOutput({tag, "_dv"},    32'(o_tx_dv), 32'h0);
        checkOutput({tag, "_data"},  32'(o_tx_data), 32'h0);
        checkOutput({tag, "_busy"},  32'(o_busy), 32'h0);
        checkOutput({tag, "_err"},   32'(o_err), 32'h0);
        checkOutput({tag, "_tx"},    32'(tx), 32'h1);
        i_reset = 1'b0;
    endtask

    task automatic waitAck(input string tag, input logic [N_REQ-1:0] expected, input int maxCycles);
        int n = 0;
        while (o_ack == '0 && n < maxCycles) begin
            @(negedge clk);
            n++;
        end
        checkOutput(tag, 32'(o_ack), 32'(expected));
    endtask

    task automatic waitIdle(input string tag, input int maxCycles);
        int n = 0;
        while ((o_busy || ser_state != S_IDLE) && n < maxCycles) begin
            @(negedge clk);
            n++;
        end
        checkOutput(tag, 32'(o_busy), 32'h0);
    endtask

    function automatic logic [9:0] getFrame(input int base);
        logic [9:0] f = 10'h3FF;
        if (rx_bits.size() >= base + 10) begin
            for (int i = 0; i < 10; i++) f = {rx_bits[base+i], f[9:1]};
        end
        return f;
    endfunction

    initial begin
        int          base;
        int          sbase;
        int          gap;
        logic [7:0]  rrBytes[5];
        rrBytes = '{8'h10, 8'h11, 8'h12, 8'h13, 8'h10};
        i_reset = 1'b1;
        applyStimulus(4'b0000, 32'h0);
        repeat (2) @(negedge clk);

        // Single frame from requester 1
        applyReset("rst");
        base = rx_bits.size();
        applyStimulus(4'b0010, 32'h0000_A500);
        @(negedge clk);
        checkOutput("sf_grant", 32'(o_grant), 32'h2);
        checkOutput("sf_dv", 32'(o_tx_dv), 32'h1);
        checkOutput("sf_data", 32'(o_tx_data), 32'hA5);
        checkOutput("sf_busy", 32'(o_busy), 32'h1);
        waitAck("sf_ack", 4'b0010, 50);
        checkOutput("sf_dv_at_ack", 32'(o_tx_dv), 32'h0);
        applyStimulus(4'b0000, 32'h0000_A500);
        @(negedge clk);
        checkOutput("sf_ack_once", 32'(o_ack), 32'h0);
        waitIdle("sf_idle", 400);
        checkOutput("sf_frame", 32'(getFrame(base)), 32'({1'b1, 8'hA5, 1'b0}));

        // Round robin with all four requests held
        applyReset("rr_rst");
        base  = rx_bits.size();
        sbase = start_cyc.size();
        applyStimulus(4'b1111, 32'h1312_1110);
        for (int k = 0; k < 5; k++) begin
            waitAck($sformatf("rr_ack%0d", k), 4'(1 << (k % 4)), 400);
            if (k == 4) applyStimulus(4'b0000, 32'h1312_1110);
            @(negedge clk);
        end
        waitIdle("rr_idle", 400);
        for (int k = 0; k < 5; k++) begin
            checkOutput($sformatf("rr_frame%0d", k), 32'(getFrame(base + 10 * k)),
                        32'({1'b1, rrBytes[k], 1'b0}));
        end
        gap = (start_cyc.size() >= sbase + 5) ? start_cyc[sbase+4] - start_cyc[sbase] : -1;
        checkOutput("rr_no_idle_bits", 32'(gap), 32'(4 * 10 * DIVISOR));

        // Data is captured at grant
        applyReset("dc_rst");
        base = rx_bits.size();
        applyStimulus(4'b0100, 32'h003C_0000);
        @(negedge clk);
        checkOutput("dc_grant", 32'(o_grant), 32'h4);
        applyStimulus(4'b0100, 32'h00FF_0000);
        @(negedge clk);
        checkOutput("dc_hold", 32'(o_tx_data), 32'h3C);
        waitAck("dc_ack", 4'b0100, 50);
        applyStimulus(4'b0000, 32'h00FF_0000);
        waitIdle("dc_idle", 400);
        checkOutput("dc_frame", 32'(getFrame(base)), 32'({1'b1, 8'h3C, 1'b0}));

        // Reset during SEND; pointer returns to requester 0
        applyReset("mr_pre");
        applyStimulus(4'b0100, 32'h005A_0000);
        waitAck("mr_ack", 4'b0100, 50);
        applyStimulus(4'b0000, 32'h005A_0000);
        repeat (20) @(negedge clk);
        applyReset("mr_rst");
        applyStimulus(4'b1010, 32'h2300_2100);
        @(negedge clk);
        checkOutput("mr_grant", 32'(o_grant), 32'h2);
        checkOutput("mr_data", 32'(o_tx_data), 32'h21);
        waitAck("mr_ack2", 4'b0010, 50);
        applyStimulus(4'b0000, 32'h0);
        waitIdle("mr_idle", 400);

`ifdef UART_TX_ARB_WATCHDOG_EN
        // Watchdog abort with the serializer never answering
        applyReset("wd_rst");
        stall      = 1'b1;
        force_busy = 1'b0;
        applyStimulus(4'b0001, 32'h0000_0077);
        @(negedge clk);
        checkOutput("wd_grant", 32'(o_grant), 32'h1);
        repeat (20) @(negedge clk);
        checkOutput("wd_err_early", 32'(o_err), 32'h0);
        checkOutput("wd_ack_early", 32'(o_ack), 32'h0);
        @(negedge clk);
        checkOutput("wd_err", 32'(o_err), 32'h1);
        checkOutput("wd_ack", 32'(o_ack), 32'h1);
        checkOutput("wd_dv", 32'(o_tx_dv), 32'h0);
        checkOutput("wd_busy", 32'(o_busy), 32'h0);
        checkOutput("wd_grant0", 32'(o_grant), 32'h0);
        applyStimulus(4'b0000, 32'h0);
        @(negedge clk);
        checkOutput("wd_err_once", 32'(o_err), 32'h0);

        // Busy arriving exactly when the counter hits TIMEOUT wins
        applyReset("wt_rst");
        applyStimulus(4'b0001, 32'h0000_0066);
        @(negedge clk);
        checkOutput("wt_grant", 32'(o_grant), 32'h1);
        repeat (20) @(negedge clk);
        force_busy = 1'b1;
        @(negedge clk);
        checkOutput("wt_ack", 32'(o_ack), 32'h1);
        checkOutput("wt_err", 32'(o_err), 32'h0);
        checkOutput("wt_dv", 32'(o_tx_dv), 32'h0);
        checkOutput("wt_busy", 32'(o_busy), 32'h1);
        applyStimulus(4'b0000, 32'h0);
        force_busy = 1'b0;
        repeat (2) @(negedge clk);
        checkOutput("wt_idle", 32'(o_busy), 32'h0);
        stall = 1'b0;
`endif

        checkOutput("mon_multi_ack", 32'(multiAck), 32'h0);
        checkOutput("mon_dv_with_ack", 32'(dvWithAck), 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", cmpCount, failCount);
        $finish;
    end

endmodule
